fnd_controller: RTL and testbench
=================================

Name: fnd_controller

Overview:
- Display stage directly downstream of the stopwatch datapath.
- Consumes the msec/sec/min/hour counter values and drives a 4-digit common-anode 7-segment (FND) module by time-multiplexed scanning.
- sw_mode selects the view: "SS.ms" (sec.msec) or "HH.MM" (hour.min).
- The decimal point blinks at 1 Hz, derived from msec. Inputs are snapshotted once per scan frame so a frame never mixes two counter states.

Parameters:
- SCAN_COUNT, 100_000, clk cycles per digit slot (1 kHz digit rate at 100 MHz; set to 4 in simulation)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- sw_mode  input  1  0 = sec.msec view, 1 = hour.min view
- msec  input  7  centiseconds, legal 0..99
- sec  input  6  seconds, legal 0..59
- min  input  6  minutes, legal 0..59
- hour  input  5  hours, legal 0..23
- fnd_com  output  4  digit enables, active-low, bit0 = rightmost digit
- fnd_data  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (async, rst=1), all registers cleared immediately:
  - scan counter = 0, scan_tick = 0, digit_sel = 0
  - snapshot {mode, msec, sec, min, hour} = 0
  - fnd_com = 4'b1111, fnd_data = 8'hFF (all dark)
- Scan counter:
  - Counts 0..SCAN_COUNT-1 and wraps.
  - scan_tick is a registered 1-cycle pulse, high in the cycle after the counter equals SCAN_COUNT-1.
  - Period is exactly SCAN_COUNT clocks.
- digit_sel (2 bits):
  - Increments on every clock with scan_tick=1 and wraps 3->0.
  - Frame = 4 slots = 4*SCAN_COUNT clocks.
- Snapshot:
  - Loaded from live inputs (including sw_mode) on the clock where scan_tick=1 and digit_sel=3, i.e. at the frame boundary.
  - Held otherwise. Input changes mid-frame are never visible until the next frame.
- Digit mapping, from the snapshot, with pair = {left value, right value}:
  - mode 0: digit3 = sec/10, digit2 = sec%10, digit1 = msec/10, digit0 = msec%10
  - mode 1: digit3 = hour/10, digit2 = hour%10, digit1 = min/10, digit0 = min%10
- Out-of-range values:
  - If a snapshot value exceeds its legal max (msec>99, sec>59, min>59, hour>23), both digits of that pair show "-".
  - "-" is segment g only: 8'hBF before dp.
- Segment code, active-low, dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
- Decimal point:
  - Only on digit2.
  - Lit (bit7 = 0) when snapshot msec < 50; dark otherwise.
  - Applies in both modes, giving a 1 Hz blink at 50% duty.
- Output registers:
  - fnd_com = ~(1 << digit_sel) and fnd_data = code(digit_sel), registered every clock from the current digit_sel and snapshot.
  - Latency: outputs reflect a digit_sel change 1 clock later.
  - Exactly one fnd_com bit is low at any time after the first clock out of reset.
- Mode change mid-frame: takes effect at the next frame boundary, never mid-frame.
- Reset mid-scan: outputs go dark asynchronously. After release, scanning restarts at digit0, showing the cleared snapshot "00.00" with dp lit.
- Arithmetic:
  - /10 and %10 are combinational on unsigned widths ≤ 7 bits.
  - Values are compared against limits before division.
  - Maximum legal tens digit is 9.

Test Plan (SCAN_COUNT=4):
- Reset then release, inputs 0 -> fnd_com cycles 1110,1101,1011,0111 with each slot held 4 clocks; fnd_data C0,C0,40,C0 (dp on digit2); outputs FF/1111 while rst=1.
- mode 0, sec=37, msec=82 applied, wait for the frame boundary -> digit0=A4(2), digit1=80(8), digit2=F8(7), digit3=B0(3); digit2 dp off because 82≥50. Then msec=12 -> digit2 = 78 next frame.
- mode 1, hour=23, min=5 -> digit0=92(5), digit1=C0(0), digit2=B0 or 30 per msec, digit3=A4(2). Toggle sw_mode mid-frame -> no change until the next boundary.
- sec=60, msec=99 -> digit3 and digit2 = BF ("-", dp off); msec digits 90,90. hour=24 in mode 1 -> hour pair shows "-".
- Change msec every clock during a frame -> all four digits of that frame match the value sampled at the preceding boundary.
- Assert rst for 1 clock mid-slot at digit2 -> immediate FF/1111; restart at digit0 the clock after release; scan_tick spacing is exactly 4 clocks from release.

Source files
------------

// File: rtl/fnd_controller.sv
// 4-digit common-anode 7-segment scanner for the stopwatch: shows SS.ms or HH.MM
// from a per-frame snapshot of the counters, with a 1 Hz blinking decimal point.
module fnd_controller #(
    parameter int unsigned SCAN_COUNT = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int unsigned CNT_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;

    logic [CNT_W-1:0] scan_cnt;
    logic             scan_tick;
    logic [1:0]       digit_sel;

    logic             snap_mode;
    logic [6:0]       snap_msec;
    logic [5:0]       snap_sec;
    logic [5:0]       snap_min;
    logic [4:0]       snap_hour;

    logic [6:0]       left_val_c;
    logic [6:0]       right_val_c;
    logic             left_bad_c;
    logic             right_bad_c;
    logic [3:0]       digit_c;
    logic             bad_c;
    logic [7:0]       seg_c;
    logic [3:0]       com_c;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hBF;
        endcase
    endfunction

    // Slot timer: scan_tick pulses in the cycle after the counter reaches its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
            digit_sel <= 2'd0;
        end else begin
            scan_tick <= (scan_cnt == CNT_W'(SCAN_COUNT - 1));
            if (scan_cnt == CNT_W'(SCAN_COUNT - 1)) begin
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            if (scan_tick) begin
                digit_sel <= digit_sel + 2'd1;
            end
        end
    end

    // Snapshot only at the frame boundary so one frame never mixes two counter states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_mode <= 1'b0;
            snap_msec <= 7'd0;
            snap_sec  <= 6'd0;
            snap_min  <= 6'd0;
            snap_hour <= 5'd0;
        end else if (scan_tick && (digit_sel == 2'd3)) begin
            snap_mode <= sw_mode;
            snap_msec <= msec;
            snap_sec  <= sec;
            snap_min  <= min;
            snap_hour <= hour;
        end
    end

    // Digit select, range check before division, segment encode and decimal point.
    always_comb begin
        left_val_c  = 7'(snap_sec);
        right_val_c = snap_msec;
        left_bad_c  = (snap_sec > 6'd59);
        right_bad_c = (snap_msec > 7'd99);
        digit_c     = 4'd0;
        bad_c       = 1'b0;
        seg_c       = 8'hFF;
        com_c       = 4'b1111;

        if (snap_mode) begin
            left_val_c  = 7'(snap_hour);
            right_val_c = 7'(snap_min);
            left_bad_c  = (snap_hour > 5'd23);
            right_bad_c = (snap_min > 6'd59);
        end

        case (digit_sel)
            2'd0: begin
                digit_c = 4'(right_val_c % 7'd10);
                bad_c   = right_bad_c;
            end
            2'd1: begin
                digit_c = 4'(right_val_c / 7'd10);
                bad_c   = right_bad_c;
            end
            2'd2: begin
                digit_c = 4'(left_val_c % 7'd10);
                bad_c   = left_bad_c;
            end
            default: begin
                digit_c = 4'(left_val_c / 7'd10);
                bad_c   = left_bad_c;
            end
        endcase

        seg_c = bad_c ? 8'hBF : seg7(digit_c);
        if ((digit_sel == 2'd2) && (snap_msec < 7'd50)) begin
            seg_c[7] = 1'b0;
        end
        com_c[digit_sel] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_com  <= 4'b1111;
            fnd_data <= 8'hFF;
        end else begin
            fnd_com  <= com_c;
            fnd_data <= seg_c;
        end
    end

endmodule

// File: tb/tb_fnd_controller.sv
// Randomized self-checking bench for fnd_controller; the reference model derives the
// displayed digit and frame boundaries from the cycle count since reset release.
module tb_fnd_controller;

    localparam int unsigned SCAN = 4;
    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_mode = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release and the frame snapshot.
    int   k = 0;
    logic s_mode = 1'b0;
    int   s_ms = 0, s_s = 0, s_mi = 0, s_h = 0;

    fnd_controller #(.SCAN_COUNT(SCAN)) dut (
        .clk(clk), .rst(rst), .sw_mode(sw_mode), .msec(msec), .sec(sec),
        .min(min), .hour(hour), .fnd_com(fnd_com), .fnd_data(fnd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_out(int kk, logic m, int ms, int s, int mi, int h);
        int sel, left, right, v, d;
        logic lb, rb, bad;
        logic [7:0] data;
        logic [3:0] com;
        if (kk == 0) return {4'hF, 8'hFF};
        // Slot 0 spans edges 1..5 (output latency from reset), then 4 edges per slot.
        sel   = (kk == 1) ? 0 : ((kk - 2) / int'(SCAN)) % 4;
        left  = m ? h : s;
        right = m ? mi : ms;
        lb    = m ? (h > 23) : (s > 59);
        rb    = m ? (mi > 59) : (ms > 99);
        v     = (sel >= 2) ? left : right;
        bad   = (sel >= 2) ? lb : rb;
        d     = (sel == 1 || sel == 3) ? v / 10 : v % 10;
        data  = bad ? 8'hBF : SEG_TAB[d];
        if (sel == 2 && ms < 50) data[7] = 1'b0;
        com = 4'hF;
        com[sel] = 1'b0;
        return {com, data};
    endfunction

    // Advance one clock; return what the display must show after this edge.
    task automatic step(output logic [3:0] ec, output logic [7:0] ed);
        @(posedge clk);
        k++;
        {ec, ed} = model_out(k, s_mode, s_ms, s_s, s_mi, s_h);
        if (k >= 17 && (k % 16) == 1) begin
            s_mode = sw_mode;
            s_ms = int'(msec); s_s = int'(sec); s_mi = int'(min); s_h = int'(hour);
        end
        #1;
    endtask

    task automatic model_reset();
        k = 0; s_mode = 1'b0; s_ms = 0; s_s = 0; s_mi = 0; s_h = 0;
    endtask

    task automatic test_reset();
        logic [3:0] ec;
        logic [7:0] ed;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_dark: com=%b data=%h, expected 1111 ff", fnd_com, fnd_data);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step(ec, ed);
            checks++;
            if (fnd_com !== ec || fnd_data !== ed) begin
                errors++;
                $display("FAIL reset_scan k=%0d: com=%b data=%h, expected %b %h", k, fnd_com, fnd_data, ec, ed);
            end
        end
    endtask

    task automatic test_sec_msec();
        logic [3:0] ec;
        logic [7:0] ed;
        sw_mode = 1'b0; sec = 6'd37; msec = 7'd82;
        for (int i = 0; i < 40; i++) begin
            step(ec, ed);
            checks++;
            if (fnd_com !== ec || fnd_data !== ed) begin
                errors++;
                $display("FAIL sec_msec k=%0d: com=%b data=%h, expected %b %h", k, fnd_com, fnd_data, ec, ed);
            end
            if (i == 20) msec = 7'd12;
        end
    endtask

    task automatic test_hour_min();
        logic [3:0] ec;
        logic [7:0] ed;
        sw_mode = 1'b1; hour = 5'd23; min = 6'd5; msec = 7'd30;
        for (int i = 0; i < 56; i++) begin
            step(ec, ed);
            checks++;
            if (fnd_com !== ec || fnd_data !== ed) begin
                errors++;
                $display("FAIL hour_min k=%0d: com=%b data=%h, expected %b %h", k, fnd_com, fnd_data, ec, ed);
            end
            if (i == 26) sw_mode = 1'b0;
            if (i == 28) msec = 7'd75;
        end
        sw_mode = 1'b1;
    endtask

    task automatic test_out_of_range();
        logic [3:0] ec;
        logic [7:0] ed;
        sw_mode = 1'b0; sec = 6'd60; msec = 7'd99;
        for (int i = 0; i < 36; i++) begin
            step(ec, ed);
            checks++;
            if (fnd_com !== ec || fnd_data !== ed) begin
                errors++;
                $display("FAIL range_sec k=%0d: com=%b data=%h, expected %b %h", k, fnd_com, fnd_data, ec, ed);
            end
        end
        sw_mode = 1'b1; hour = 5'd24; min = 6'd59; msec = 7'd100;
        for (int i = 0; i < 36; i++) begin
            step(ec, ed);
            checks++;
            if (fnd_com !== ec || fnd_data !== ed) begin
                errors++;
                $display("FAIL range_hour k=%0d: com=%b data=%h, expected %b %h", k, fnd_com, fnd_data, ec, ed);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ec;
        logic [7:0] ed;
        for (int i = 0; i < 400; i++) begin
            step(ec, ed);
            checks++;
            if (fnd_com !== ec || fnd_data !== ed) begin
                errors++;
                $display("FAIL random k=%0d: com=%b data=%h, expected %b %h", k, fnd_com, fnd_data, ec, ed);
            end
            msec = 7'($urandom_range(0, 127));
            if (i % 16 == 5) begin
                sw_mode = 1'($urandom);
                sec  = 6'($urandom_range(0, 63));
                min  = 6'($urandom_range(0, 63));
                hour = 5'($urandom_range(0, 31));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ec;
        logic [7:0] ed;
        int guard;
        guard = 0;
        ec = 4'hF;
        while (ec !== 4'b1011 && guard < 64) begin
            step(ec, ed);
            guard++;
        end
        checks++;
        if (ec !== 4'b1011) begin
            errors++;
            $display("FAIL reset_mid_reach: expected slot 1011 not reached, got %b", ec);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_async: com=%b data=%h, expected 1111 ff", fnd_com, fnd_data);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        sw_mode = 1'b0; sec = 6'd12; msec = 7'd34;
        for (int i = 0; i < 48; i++) begin
            step(ec, ed);
            checks++;
            if (fnd_com !== ec || fnd_data !== ed) begin
                errors++;
                $display("FAIL reset_mid_restart k=%0d: com=%b data=%h, expected %b %h", k, fnd_com, fnd_data, ec, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sec_msec();
        test_hour_min();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
